// File: rtl/alu_pkg.sv
// alu_pkg: shared opcode definitions for the alu_pipe datapath.
//   op_t     : 3-bit opcode type
//   OP_*     : opcode encodings (OP_ACC/OP_ACLR are only decoded when the
//              build defines ALU_ACC_EN; otherwise they are reserved)
package alu_pkg;

    typedef logic [2:0] op_t;

    localparam op_t OP_AND  = 3'b000;
    localparam op_t OP_OR   = 3'b001;
    localparam op_t OP_XOR  = 3'b010;
    localparam op_t OP_ADD  = 3'b011;
    localparam op_t OP_SUB  = 3'b100;
    localparam op_t OP_ACC  = 3'b101;
    localparam op_t OP_ACLR = 3'b110;
    localparam op_t OP_RSVD = 3'b111;

endpackage

// File: rtl/alu_pipe_if.sv
// alu_pipe_if: operand and result handshakes of alu_pipe.
//   in_valid/in_ready   : operand beat handshake (a, b, carry_in, op)
//   out_valid/out_ready : result beat handshake (result, carry_out, zero, err)
// Modports:
//   master : operand source / result consumer
//   slave  : the ALU pipeline
interface alu_pipe_if #(
    parameter int WIDTH = 4
);
    import alu_pkg::*;

    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             carry_in;
    op_t              op;

    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] result;
    logic             carry_out;
    logic             zero;
    logic             err;

    modport master (
        output in_valid, a, b, carry_in, op, out_ready,
        input  in_ready, out_valid, result, carry_out, zero, err
    );

    modport slave (
        input  in_valid, a, b, carry_in, op, out_ready,
        output in_ready, out_valid, result, carry_out, zero, err
    );

endinterface

// File: rtl/alu_core.sv
// alu_core: combinational WIDTH-bit ALU function.
//   a, b, carry_in, op : operands and opcode
//   acc                : accumulator value (port exists only with ALU_ACC_EN)
//   result, carry_out  : operation result; carry_out is the ADD/ACC carry,
//                        the SUB no-borrow, and 0 for logic ops
//   err                : opcode not supported in this build (result forced 0)
// Build option: ALU_ACC_EN enables the ACC/ACLR opcodes.
module alu_core
    import alu_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             carry_in,
    input  op_t              op,
`ifdef ALU_ACC_EN
    input  logic [WIDTH-1:0] acc,
`endif
    output logic [WIDTH-1:0] result,
    output logic             carry_out,
    output logic             err
);

    logic [WIDTH:0] sum;

    always_comb begin
        sum       = '0;
        result    = '0;
        carry_out = 1'b0;
        err       = 1'b0;
        case (op)
            OP_AND: result = a & b;
            OP_OR:  result = a | b;
            OP_XOR: result = a ^ b;
            OP_ADD: begin
                sum = {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, carry_in};
                {carry_out, result} = sum;
            end
            OP_SUB: begin
                // two's-complement subtract; the carry out is the no-borrow flag
                sum = {1'b0, a} + {1'b0, ~b} + {{WIDTH{1'b0}}, 1'b1};
                {carry_out, result} = sum;
            end
`ifdef ALU_ACC_EN
            OP_ACC: begin
                sum = {1'b0, acc} + {1'b0, a} + {{WIDTH{1'b0}}, carry_in};
                {carry_out, result} = sum;
            end
            OP_ACLR: begin
                result    = '0;
                carry_out = 1'b0;
            end
`endif
            default: err = 1'b1;
        endcase
    end

endmodule

// File: rtl/alu_pipe.sv
// alu_pipe: two-stage pipelined ALU with valid/ready on both sides.
//   clk   : rising-edge clock
//   reset : asynchronous active-high reset
//   bus   : alu_pipe_if.slave (operand and result handshakes)
// S1 registers the operand beat; S2 registers the computed result and flags.
// S2 reloads whenever it is empty or its beat is being taken, so a full
// pipeline sustains one beat per cycle and holds two beats under backpressure.
// Build option: ALU_ACC_EN adds the accumulator register and ACC/ACLR opcodes.
module alu_pipe
    import alu_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic       clk,
    input  logic       reset,
    alu_pipe_if.slave  bus
);

    logic             s1_valid;
    logic [WIDTH-1:0] s1_a;
    logic [WIDTH-1:0] s1_b;
    logic             s1_cin;
    op_t              s1_op;

    logic             s2_load;
    logic             s1_adv;
    logic             in_fire;

    logic [WIDTH-1:0] core_result;
    logic             core_carry;
    logic             core_err;

`ifdef ALU_ACC_EN
    logic [WIDTH-1:0] acc;
`endif

    assign s2_load = ~bus.out_valid | bus.out_ready;
    assign s1_adv  = s1_valid & s2_load;
    // held low during reset so nothing is offered as accepted while flops are cleared
    assign bus.in_ready = ~reset & (~s1_valid | s2_load);
    assign in_fire = bus.in_valid & bus.in_ready;

    alu_core #(
        .WIDTH (WIDTH)
    ) u_core (
        .a         (s1_a),
        .b         (s1_b),
        .carry_in  (s1_cin),
        .op        (s1_op),
`ifdef ALU_ACC_EN
        .acc       (acc),
`endif
        .result    (core_result),
        .carry_out (core_carry),
        .err       (core_err)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s1_valid <= 1'b0;
            s1_a     <= '0;
            s1_b     <= '0;
            s1_cin   <= 1'b0;
            s1_op    <= OP_AND;
        end else if (in_fire) begin
            s1_valid <= 1'b1;
            s1_a     <= bus.a;
            s1_b     <= bus.b;
            s1_cin   <= bus.carry_in;
            s1_op    <= bus.op;
        end else if (s1_adv) begin
            s1_valid <= 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            bus.out_valid <= 1'b0;
            bus.result    <= '0;
            bus.carry_out <= 1'b0;
            bus.zero      <= 1'b0;
            bus.err       <= 1'b0;
        end else if (s2_load) begin
            bus.out_valid <= s1_valid;
            if (s1_valid) begin
                bus.result    <= core_result;
                bus.carry_out <= core_carry;
                bus.zero      <= (core_result == '0);
                bus.err       <= core_err;
            end
        end
    end

`ifdef ALU_ACC_EN
    // acc changes at the edge the beat enters S2, so a following ACC beat
    // sitting in S1 already sees the new value
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            acc <= '0;
        end else if (s1_adv) begin
            if (s1_op == OP_ACC) begin
                acc <= core_result;
            end else if (s1_op == OP_ACLR) begin
                acc <= '0;
            end
        end
    end
`endif

endmodule

// File: tb/tb_alu_pipe.sv
module tb_alu_pipe;
    import alu_pkg::*;

    localparam int WIDTH = 4;
    localparam int MODV  = 1 << WIDTH;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    alu_pipe_if #(.WIDTH(WIDTH)) bus ();

    alu_pipe #(.WIDTH(WIDTH)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    typedef struct {
        int unsigned res;
        bit          c;
        bit          z;
        bit          e;
    } beat_t;

    int          checks = 0;
    int          errors = 0;
    beat_t       exp_q[$];
    int unsigned model_acc = 0;
    bit          mon_en = 1'b0;
    bit          rnd_ready = 1'b0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    // reference model: arithmetic straight from the opcode definitions
    function automatic beat_t model(input int unsigned op, input int unsigned a,
                                    input int unsigned b, input int unsigned ci);
        beat_t       t;
        int unsigned s;
        t = '{default: 0};
        case (op)
            0: t.res = a & b;
            1: t.res = a | b;
            2: t.res = a ^ b;
            3: begin
                s = a + b + ci;
                t.res = s % MODV;
                t.c = (s >= MODV);
            end
            4: begin
                t.res = (a + MODV - b) % MODV;
                t.c = (a >= b);
            end
`ifdef ALU_ACC_EN
            5: begin
                s = model_acc + a + ci;
                t.res = s % MODV;
                t.c = (s >= MODV);
                model_acc = t.res;
            end
            6: model_acc = 0;
`endif
            default: t.e = 1'b1;
        endcase
        t.z = (t.res == 0);
        return t;
    endfunction

    // scoreboard: log accepted operands, compare delivered results in order
    initial begin
        beat_t e;
        forever begin
            @(negedge clk);
            if (mon_en && !reset) begin
                if (bus.out_valid && bus.out_ready) begin
                    check("beat_expected", 32'(exp_q.size() > 0), 32'd1);
                    if (exp_q.size() > 0) begin
                        e = exp_q.pop_front();
                        check("result", 32'(bus.result), e.res);
                        check("carry_out", 32'(bus.carry_out), 32'(e.c));
                        check("zero", 32'(bus.zero), 32'(e.z));
                        check("err", 32'(bus.err), 32'(e.e));
                    end
                end
                if (bus.in_valid && bus.in_ready)
                    exp_q.push_back(model(32'(bus.op), 32'(bus.a), 32'(bus.b), 32'(bus.carry_in)));
            end
        end
    end

    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (rnd_ready) bus.out_ready = 1'($urandom_range(0, 1));
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "simulation did not complete");
    end

    task automatic wait_accept();
        int k = 0;
        @(negedge clk);
        while (!bus.in_ready && k < 100) begin
            @(negedge clk);
            k++;
        end
        check("accept_timeout", 32'(bus.in_ready), 32'd1);
        @(posedge clk);
        #1;
    endtask

    task automatic send(input int unsigned o, input int unsigned av,
                        input int unsigned bv, input int unsigned ci);
        bus.op       = o[2:0];
        bus.a        = av[WIDTH-1:0];
        bus.b        = bv[WIDTH-1:0];
        bus.carry_in = ci[0];
        bus.in_valid = 1'b1;
        wait_accept();
        bus.in_valid = 1'b0;
    endtask

    task automatic drain();
        int k = 0;
        while ((exp_q.size() != 0 || bus.out_valid) && k < 60) begin
            @(posedge clk);
            #1;
            k++;
        end
        check("drain", 32'(exp_q.size()), 32'd0);
    endtask

    initial begin
        reset         = 1'b1;
        bus.in_valid  = 1'b0;
        bus.a         = '0;
        bus.b         = '0;
        bus.carry_in  = 1'b0;
        bus.op        = OP_AND;
        bus.out_ready = 1'b1;

        #1;
        check("in_ready_in_reset", 32'(bus.in_ready), 32'd0);
        repeat (2) @(posedge clk);
        #1;
        check("rst_out_valid", 32'(bus.out_valid), 32'd0);
        check("rst_result", 32'(bus.result), 32'd0);
        check("rst_carry", 32'(bus.carry_out), 32'd0);
        check("rst_zero", 32'(bus.zero), 32'd0);
        check("rst_err", 32'(bus.err), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        #1;
        check("in_ready_after_release", 32'(bus.in_ready), 32'd1);
        mon_en = 1'b1;

        // latency: accepted at edge N, visible after edge N+1
        bus.op = OP_AND; bus.a = 4'h1; bus.b = 4'hE; bus.carry_in = 1'b0;
        bus.in_valid = 1'b1;
        @(negedge clk);
        check("lat_accept", 32'(bus.in_ready), 32'd1);
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        check("lat_n", 32'(bus.out_valid), 32'd0);
        @(posedge clk);
        #1;
        check("lat_n1", 32'(bus.out_valid), 32'd1);
        check("lat_result", 32'(bus.result), 32'd0);
        check("lat_zero", 32'(bus.zero), 32'd1);

        send(1, 4'h1, 4'hE, 0);
        send(2, 4'h1, 4'hE, 0);
        send(3, 4'hF, 4'hF, 1);
        send(3, 4'h0, 4'h0, 0);
        send(4, 4'h3, 4'h5, 0);
        send(4, 4'h5, 4'h3, 0);
        send(4, 4'h7, 4'h7, 0);
        send(7, 4'h9, 4'h6, 1);
        drain();

        // backpressure: two beats fill the pipe, the third is refused
        bus.out_ready = 1'b0;
        send(3, 4'h2, 4'h3, 0);
        send(2, 4'h5, 4'hA, 0);
        bus.op = OP_AND; bus.a = 4'hF; bus.b = 4'h3; bus.carry_in = 1'b0;
        bus.in_valid = 1'b1;
        repeat (3) begin
            @(negedge clk);
            check("bp_in_ready", 32'(bus.in_ready), 32'd0);
            check("bp_out_valid", 32'(bus.out_valid), 32'd1);
            check("bp_held_result", 32'(bus.result), 32'd5);
        end
        @(posedge clk);
        #1;
        bus.out_ready = 1'b1;
        wait_accept();
        bus.in_valid = 1'b0;
        send(4, 4'h1, 4'h2, 0);
        drain();

        // randomized stream with random output throttling
        rnd_ready = 1'b1;
        for (int i = 0; i < 60; i++) begin
            send($urandom_range(0, 7), $urandom_range(0, MODV - 1),
                 $urandom_range(0, MODV - 1), $urandom_range(0, 1));
            if ($urandom_range(0, 3) == 0) begin
                @(posedge clk);
                #1;
            end
        end
        rnd_ready = 1'b0;
        @(posedge clk);
        #1;
        bus.out_ready = 1'b1;
        drain();

        // accumulator sequence (reserved opcodes when the feature is absent)
        send(6, 0, 0, 0);
        send(5, 4'h3, 0, 0);
        send(5, 4'h4, 4'h9, 0);
        send(5, 4'hA, 0, 1);
        drain();

        // reset with two beats in flight
        bus.out_ready = 1'b0;
        send(3, 4'h1, 4'h1, 0);
        send(1, 4'h2, 4'h4, 0);
        #2;
        reset = 1'b1;
        mon_en = 1'b0;
        #1;
        check("midrst_out_valid", 32'(bus.out_valid), 32'd0);
        check("midrst_in_ready", 32'(bus.in_ready), 32'd0);
        exp_q.delete();
        model_acc = 0;
        @(negedge clk);
        reset = 1'b0;
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1;
        mon_en = 1'b1;
        repeat (4) begin
            @(negedge clk);
            check("no_stale_beat", 32'(bus.out_valid), 32'd0);
        end
        @(posedge clk);
        #1;
        send(5, 4'h1, 0, 0);
        drain();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
